// File: rtl/work_scheduler.sv
// work_scheduler
// Sequences the Decred miner core. A host work unit is loaded into the miner
// with a one-cycle load strobe. The nonce sweep is then tracked through four
// phases: load, blanking of stale pipeline results, the run itself, and a
// drain of the hash pipeline. Golden nonces are tagged with a work ID and
// queued in a small first-word-fall-through result FIFO.
//
// Optional build macro: WORK_SCHEDULER_STATS_EN
//   When defined, found_count counts every accepted golden nonce.
//   When undefined, found_count is tied to zero.
//
// Ports:
//   clk, reset_n         clock (rising edge) and async active-low reset
//   work_valid/ready     host work handshake; work_data = {midstate, data}
//   miner_block          registered block presented to the miner
//   miner_reset          one-cycle miner load strobe
//   golden_nonce(_found) result reported by the miner
//   result_*             FIFO head and pop handshake towards the host
//   busy                 sweep in progress
//   exhausted            one-cycle pulse when the sweep completes
//   overflow             sticky; a result was dropped on a full FIFO
//   found_count          accepted-result statistics counter
//
// state | meaning
// IDLE  | no work; results ignored, miner_block held
// LOAD  | miner_reset asserted, scan counter cleared
// BLANK | PIPE_LAT+2 cycles; the pipeline still holds stale results
// RUN   | nonce sweep; results accepted
// DRAIN | PIPE_LAT+2 cycles; results still emerging from the pipeline
module work_scheduler #(
    parameter int          PIPE_LAT    = 31,
    parameter logic [31:0] NONCE_LIMIT = 32'hFFFF_FFFF,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          TAG_W       = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             work_valid,
    input  logic [351:0]     work_data,
    output logic             work_ready,
    output logic [351:0]     miner_block,
    output logic             miner_reset,
    input  logic [31:0]      golden_nonce,
    input  logic             golden_nonce_found,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [31:0]      result_nonce,
    output logic [TAG_W-1:0] result_tag,
    output logic             busy,
    output logic             exhausted,
    output logic             overflow,
    output logic [31:0]      found_count
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_BLANK, S_RUN, S_DRAIN} state_t;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(PIPE_LAT + 2) + 1;
    localparam logic [CW-1:0] PHASE_LAST = CW'(PIPE_LAT + 1);
    // Compared at 33 bits so the default all-ones limit is not a degenerate compare.
    localparam logic [32:0] LIMIT_EXT = {1'b0, NONCE_LIMIT};

    state_t            state;
    logic [TAG_W-1:0]  tag;
    logic [31:0]       scan_cnt;
    logic [CW-1:0]     phase_cnt;

    logic [31:0]       fifo_nonce [FIFO_DEPTH];
    logic [TAG_W-1:0]  fifo_tag   [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;

    logic accept, take, pop, full, empty, push, drop, scan_sat;

    assign work_ready = (state != S_LOAD);
    assign accept     = work_valid && work_ready;
    assign take       = golden_nonce_found && (state == S_RUN || state == S_DRAIN)
                        && ({1'b0, golden_nonce} <= LIMIT_EXT);
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = result_valid && result_ready;
    // A same-cycle pop frees the head slot, so a push into a full FIFO still lands.
    assign push       = take && (!full || pop);
    assign drop       = take && full && !pop;
    assign scan_sat   = ({1'b0, scan_cnt} >= LIMIT_EXT);

    assign result_valid = !empty;
    assign result_nonce = empty ? '0 : fifo_nonce[rd_ptr[AW-1:0]];
    assign result_tag   = empty ? '0 : fifo_tag[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            miner_block <= '0;
            miner_reset <= 1'b0;
            tag         <= '0;
            scan_cnt    <= '0;
            phase_cnt   <= '0;
            busy        <= 1'b0;
            exhausted   <= 1'b0;
        end else begin
            miner_reset <= 1'b0;
            exhausted   <= 1'b0;
            if (accept) begin
                miner_block <= work_data;
                tag         <= tag + 1'b1;
                miner_reset <= 1'b1;
                busy        <= 1'b1;
                state       <= S_LOAD;
            end else begin
                case (state)
                    S_LOAD: begin
                        scan_cnt  <= '0;
                        phase_cnt <= PHASE_LAST;
                        state     <= S_BLANK;
                    end
                    S_BLANK: begin
                        if (!scan_sat) scan_cnt <= scan_cnt + 1'b1;
                        if (phase_cnt == '0) state <= S_RUN;
                        else phase_cnt <= phase_cnt - 1'b1;
                    end
                    S_RUN: begin
                        if (scan_cnt == NONCE_LIMIT) begin
                            phase_cnt <= PHASE_LAST;
                            state     <= S_DRAIN;
                        end else if (!scan_sat) begin
                            scan_cnt <= scan_cnt + 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        if (phase_cnt == '0) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            phase_cnt <= phase_cnt - 1'b1;
                            // Pulse lands in the final drain cycle.
                            if (phase_cnt == CW'(1)) exhausted <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_nonce[i] <= '0;
                fifo_tag[i]   <= '0;
            end
        end else begin
            if (push) begin
                fifo_nonce[wr_ptr[AW-1:0]] <= golden_nonce;
                fifo_tag[wr_ptr[AW-1:0]]   <= tag;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (accept) overflow <= 1'b0;
            if (drop)   overflow <= 1'b1;
        end
    end

`ifdef WORK_SCHEDULER_STATS_EN
    logic [31:0] found_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  found_q <= '0;
        else if (take) found_q <= found_q + 1'b1;
    end
    assign found_count = found_q;
`else
    assign found_count = 32'd0;
`endif

endmodule
